// File: rtl/mmio_verteiler_pkg.sv
// Shared definitions for the data-side MMIO splitter: FSM encodings, IO select bit,
// peripheral register offsets relative to NUM_OUT and the index decoder.
package mmio_verteiler_pkg;

  localparam int unsigned IO_BIT = 31;

  localparam logic [1:0] LEERLAUF   = 2'd0;
  localparam logic [1:0] CACHE      = 2'd1;
  localparam logic [1:0] IO_ANTWORT = 2'd2;
  localparam logic [1:0] NACHLAUF   = 2'd3;

  localparam int unsigned OFF_EIN       = 0;
  localparam int unsigned OFF_ZAEHLER   = 1;
  localparam int unsigned OFF_VERGLEICH = 2;
  localparam int unsigned OFF_STATUS    = 3;

  typedef enum logic [2:0] {
    REG_AUS,
    REG_EIN,
    REG_ZAEHLER,
    REG_VERGLEICH,
    REG_STATUS,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_index(input int unsigned idx, input int unsigned num_out);
    reg_sel_e sel;
    if (idx < num_out)                        sel = REG_AUS;
    else if (idx == num_out + OFF_EIN)        sel = REG_EIN;
    else if (idx == num_out + OFF_ZAEHLER)    sel = REG_ZAEHLER;
    else if (idx == num_out + OFF_VERGLEICH)  sel = REG_VERGLEICH;
    else if (idx == num_out + OFF_STATUS)     sel = REG_STATUS;
    else                                      sel = REG_NONE;
    return sel;
  endfunction

endpackage

// File: rtl/mmio_verteiler_if.sv
// CPU data-port request/acknowledge bus; the CPU is master, mmio_verteiler the slave.
interface mmio_verteiler_if;
  logic [31:0] DatenAdresse;
  logic [31:0] DatenRaus;
  logic        LeseDaten;
  logic        SchreibeDaten;
  logic [31:0] DatenRein;
  logic        DatenGeladen;
  logic        DatenGespeichert;

  modport master (
    output DatenAdresse, DatenRaus, LeseDaten, SchreibeDaten,
    input  DatenRein, DatenGeladen, DatenGespeichert
  );

  modport slave (
    input  DatenAdresse, DatenRaus, LeseDaten, SchreibeDaten,
    output DatenRein, DatenGeladen, DatenGespeichert
  );
endinterface

// File: rtl/mmio_verteiler_timer.sv
// Free-running 32-bit cycle counter with compare register and sticky match flag.
module mmio_verteiler_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        zaehler_clr_i,
  input  logic        vergleich_we_i,
  input  logic [31:0] vergleich_wert_i,
  input  logic        status_clr_i,
  output logic [31:0] zaehler_o,
  output logic [31:0] vergleich_o,
  output logic        flag_o
);

  logic [31:0] zaehler_q, zaehler_d;
  logic [31:0] vergleich_q, vergleich_d;
  logic        flag_q, flag_d;
  logic        treffer;

  // Match uses the counter's next value against the old compare value, so a
  // freshly written compare only matters from the following cycle.
  always_comb begin
    zaehler_d   = zaehler_clr_i ? '0 : zaehler_q + 32'd1;
    vergleich_d = vergleich_we_i ? vergleich_wert_i : vergleich_q;
    treffer     = (zaehler_d == vergleich_q);
    flag_d      = treffer | (flag_q & ~status_clr_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zaehler_q   <= '0;
      vergleich_q <= '0;
      flag_q      <= 1'b0;
    end else begin
      zaehler_q   <= zaehler_d;
      vergleich_q <= vergleich_d;
      flag_q      <= flag_d;
    end
  end

  assign zaehler_o   = zaehler_q;
  assign vergleich_o = vergleich_q;
  assign flag_o      = flag_q;

endmodule

// File: rtl/mmio_verteiler.sv
// Data-side address decoder: addr[31]=0 passes through to DatenCache, addr[31]=1
// is served from the local peripheral registers (outputs, inputs, timer).
module mmio_verteiler
  import mmio_verteiler_pkg::*;
#(
  parameter int unsigned NUM_OUT   = 4,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned ADDRBITS  = 4
) (
  input  logic                          Clock,
  input  logic                          Reset,
  mmio_verteiler_if.slave               cpu,
  output logic                          CacheLesen,
  output logic                          CacheSchreiben,
  output logic [31:0]                   CacheAdresse,
  output logic [31:0]                   CacheSchreibDaten,
  input  logic [31:0]                   CacheLesDaten,
  input  logic                          CacheDatenGelesen,
  input  logic                          CacheDatenGeschrieben,
  input  logic [IN_WIDTH-1:0]           Eingaenge,
  output logic [NUM_OUT*OUT_WIDTH-1:0]  Ausgaenge,
  output logic                          TimerTreffer,
  output logic                          FehlerZugriff
);

  logic [1:0]           zustand_q, zustand_d;
  logic [OUT_WIDTH-1:0] aus_q [NUM_OUT];
  logic [OUT_WIDTH-1:0] aus_d [NUM_OUT];
  logic [IN_WIDTH-1:0]  sync1_q, sync2_q;
  logic [31:0]          io_daten_q, io_daten_d;
  logic                 io_lesen_q, io_lesen_d;
  logic                 io_schreiben_q, io_schreiben_d;
  logic                 fehler_q, fehler_d;

  logic                 anfrage, schreiben, in_cache;
  logic                 cache_rd_ack, cache_wr_ack;
  logic [ADDRBITS-1:0]  idx;
  reg_sel_e             sel;
  logic [31:0]          lese_wert;

  logic                 zaehler_clr, vergleich_we, status_clr;
  logic [31:0]          zaehler, vergleich;
  logic                 flag;

  assign anfrage   = cpu.LeseDaten | cpu.SchreibeDaten;
  assign schreiben = cpu.SchreibeDaten;
  assign idx       = cpu.DatenAdresse[ADDRBITS-1:0];
  assign sel       = decode_index(32'(idx), NUM_OUT);

  always_comb begin
    lese_wert = '0;
    case (sel)
      REG_AUS: begin
        for (int unsigned k = 0; k < NUM_OUT; k++) begin
          if (idx == ADDRBITS'(k)) lese_wert = 32'(aus_q[k]);
        end
      end
      REG_EIN:       lese_wert = 32'(sync2_q);
      REG_ZAEHLER:   lese_wert = zaehler;
      REG_VERGLEICH: lese_wert = vergleich;
      REG_STATUS:    lese_wert = {31'b0, flag};
      default:       lese_wert = '0;
    endcase
  end

  // IO side effects happen only on the LEERLAUF edge; the ack/data/error
  // registers default to 0 so they are high exactly for the IO_ANTWORT cycle.
  always_comb begin
    zustand_d      = zustand_q;
    aus_d          = aus_q;
    io_daten_d     = '0;
    io_lesen_d     = 1'b0;
    io_schreiben_d = 1'b0;
    fehler_d       = 1'b0;
    zaehler_clr    = 1'b0;
    vergleich_we   = 1'b0;
    status_clr     = 1'b0;
    case (zustand_q)
      LEERLAUF: begin
        if (anfrage) begin
          if (cpu.DatenAdresse[IO_BIT]) begin
            zustand_d      = IO_ANTWORT;
            io_schreiben_d = schreiben;
            io_lesen_d     = ~schreiben;
            fehler_d       = (sel == REG_NONE);
            if (schreiben) begin
              case (sel)
                REG_AUS: begin
                  for (int unsigned k = 0; k < NUM_OUT; k++) begin
                    if (idx == ADDRBITS'(k)) aus_d[k] = cpu.DatenRaus[OUT_WIDTH-1:0];
                  end
                end
                REG_ZAEHLER:   zaehler_clr  = 1'b1;
                REG_VERGLEICH: vergleich_we = 1'b1;
                REG_STATUS:    status_clr   = cpu.DatenRaus[0];
                default:       ;
              endcase
            end else begin
              io_daten_d = lese_wert;
            end
          end else begin
            zustand_d = CACHE;
          end
        end
      end
      CACHE:      if (cache_rd_ack | cache_wr_ack) zustand_d = NACHLAUF;
      IO_ANTWORT: zustand_d = NACHLAUF;
      NACHLAUF:   if (!anfrage) zustand_d = LEERLAUF;
      default:    zustand_d = LEERLAUF;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q      <= LEERLAUF;
      aus_q          <= '{default: '0};
      sync1_q        <= '0;
      sync2_q        <= '0;
      io_daten_q     <= '0;
      io_lesen_q     <= 1'b0;
      io_schreiben_q <= 1'b0;
      fehler_q       <= 1'b0;
    end else begin
      zustand_q      <= zustand_d;
      aus_q          <= aus_d;
      sync1_q        <= Eingaenge;
      sync2_q        <= sync1_q;
      io_daten_q     <= io_daten_d;
      io_lesen_q     <= io_lesen_d;
      io_schreiben_q <= io_schreiben_d;
      fehler_q       <= fehler_d;
    end
  end

  mmio_verteiler_timer u_timer (
    .clk_i            (Clock),
    .rst_i            (Reset),
    .zaehler_clr_i    (zaehler_clr),
    .vergleich_we_i   (vergleich_we),
    .vergleich_wert_i (cpu.DatenRaus),
    .status_clr_i     (status_clr),
    .zaehler_o        (zaehler),
    .vergleich_o      (vergleich),
    .flag_o           (flag)
  );

  // Simultaneous read and write requests are treated as a write.
  assign in_cache          = (zustand_q == CACHE);
  assign CacheSchreiben    = in_cache & cpu.SchreibeDaten;
  assign CacheLesen        = in_cache & cpu.LeseDaten & ~cpu.SchreibeDaten;
  assign CacheAdresse      = cpu.DatenAdresse;
  assign CacheSchreibDaten = cpu.DatenRaus;
  assign cache_rd_ack      = CacheLesen & CacheDatenGelesen;
  assign cache_wr_ack      = CacheSchreiben & CacheDatenGeschrieben;

  assign cpu.DatenGeladen     = cache_rd_ack | io_lesen_q;
  assign cpu.DatenGespeichert = cache_wr_ack | io_schreiben_q;
  assign cpu.DatenRein        = cache_rd_ack ? CacheLesDaten :
                                io_lesen_q   ? io_daten_q    : '0;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_aus
    assign Ausgaenge[g*OUT_WIDTH +: OUT_WIDTH] = aus_q[g];
  end

  assign TimerTreffer  = flag;
  assign FehlerZugriff = fehler_q;

endmodule
